// File: rtl/seg_pkg.sv
// Shared constants for the three-digit scanned seven-segment display.
// Active-low segment codes {g,f,e,d,c,b,a}, converter states, digit count.
// No timing or flow control of its own.
package seg_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry [n] is the code for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) begin
            s = SEG_TABLE[d];
        end
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 7-bit binary to three BCD digits.
// Latency: start sampled in IDLE, 7 SHIFT cycles, done high in the LOAD cycle.
// start is ignored while busy; no other backpressure.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic        clk,
    input  logic        clc,
    input  logic        start,
    input  logic [6:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state;
    logic [6:0]  sh_bin;
    logic [11:0] sh_bcd;
    logic [2:0]  cnt;
    logic [11:0] bcd_adj;

    // Correct every nibble that would overflow past 9 once doubled.
    always_comb begin
        bcd_adj = sh_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sh_bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = sh_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            state  <= IDLE;
            busy   <= 1'b0;
            sh_bin <= '0;
            sh_bcd <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_bin <= bin;
                        sh_bcd <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                        busy   <= 1'b1;
                    end
                end
                SHIFT: begin
                    {sh_bcd, sh_bin} <= {bcd_adj, sh_bin} << 1;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd6) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done = (state == LOAD);
    assign bcd  = sh_bcd;

endmodule

// File: rtl/seg_scan_display.sv
// Binary count to scanned three-digit seven-segment display; LEADING_ZERO_BLANK_EN blanks leading zeros.
// New digits land 9 cycles after value is sampled; seg/an lag the scan index by one register.
// value changes during a conversion are picked up when the converter returns to IDLE.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       clc,
    input  logic [6:0] value,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       busy
);

    localparam logic [19:0] REFRESH_LAST = 20'(REFRESH_DIV - 1);

    logic        dirty;
    logic [6:0]  last_value;
    logic        start;
    logic        conv_busy;
    logic        conv_done;
    logic [11:0] bcd;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic [19:0] refresh_cnt;
    logic [1:0]  idx;
    logic [6:0]  seg_next;
    logic [2:0]  an_next;

    // dirty forces a conversion right after reset even when value is 0.
    assign start = !conv_busy && (dirty || (value != last_value));

    bin2bcd_seq u_conv (
        .clk   (clk),
        .clc   (clc),
        .start (start),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    assign busy = conv_busy;

    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            dirty      <= 1'b1;
            last_value <= '0;
        end else if (start) begin
            dirty      <= 1'b0;
            last_value <= value;
        end
    end

    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            hund  <= '0;
            tens  <= '0;
            units <= '0;
        end else if (conv_done) begin
            hund  <= bcd[11:8];
            tens  <= bcd[7:4];
            units <= bcd[3:0];
        end
    end

    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt <= '0;
            idx         <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 20'd1;
        end
    end

    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = ~(3'b001 << idx);
        case (idx)
            2'd0: seg_next = seg_encode(units);
            2'd1: begin
                seg_next = seg_encode(tens);
`ifdef LEADING_ZERO_BLANK_EN
                if (hund == 4'd0 && tens == 4'd0) begin
                    seg_next = SEG_BLANK;
                end
`endif
            end
            2'd2: begin
                seg_next = seg_encode(hund);
`ifdef LEADING_ZERO_BLANK_EN
                if (hund == 4'd0) begin
                    seg_next = SEG_BLANK;
                end
`endif
            end
            default: begin
                seg_next = SEG_BLANK;
                an_next  = 3'b111;
            end
        endcase
    end

    // seg and an share one register stage so a digit switch is atomic.
    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            seg <= SEG_BLANK;
            an  <= 3'b111;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with REFRESH_DIV=4; honours LEADING_ZERO_BLANK_EN.
module tb_seg_scan_display;

    logic       clk;
    logic       clc;
    logic [6:0] value;
    logic [6:0] seg;
    logic [2:0] an;
    logic       busy;

    int total = 0;
    int bad   = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif
    localparam logic [6:0] ZERO_LEAD = BL ? 7'h7F : 7'h40;

    seg_scan_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .clc   (clc),
        .value (value),
        .seg   (seg),
        .an    (an),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        if (obs != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic count_while(input logic lvl, output int n);
        n = 0;
        while (busy == lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Watch 24 cycles (two frames) and check per-slot codes and lit durations.
    task automatic capture(input string name, input logic [6:0] eh,
                           input logic [6:0] et, input logic [6:0] eu);
        logic [6:0] sv [3];
        int seen [3];
        int incons, illegal, run, k;
        logic [2:0] prev_an;
        bit first;
        incons = 0; illegal = 0; run = 0; first = 1'b1; prev_an = 3'b111;
        for (int j = 0; j < 3; j++) begin
            sv[j] = 7'h00;
            seen[j] = 0;
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            case (an)
                3'b110:  k = 0;
                3'b101:  k = 1;
                3'b011:  k = 2;
                default: k = -1;
            endcase
            if (k < 0) begin
                illegal++;
            end else begin
                if (seen[k] == 0) sv[k] = seg;
                else if (sv[k] != seg) incons++;
                seen[k]++;
            end
            if (i == 0) begin
                prev_an = an;
                run = 1;
            end else if (an == prev_an) begin
                run++;
            end else begin
                if (!first) chk({name, "_lit"}, run, 4);
                first = 1'b0;
                prev_an = an;
                run = 1;
            end
        end
        chk({name, "_an_legal"}, illegal, 0);
        chk({name, "_stable"}, incons, 0);
        chk({name, "_n_units"}, seen[0], 8);
        chk({name, "_n_tens"}, seen[1], 8);
        chk({name, "_n_hund"}, seen[2], 8);
        chk({name, "_units"}, sv[0], eu);
        chk({name, "_tens"}, sv[1], et);
        chk({name, "_hund"}, sv[2], eh);
    endtask

    task automatic convert(input string name, input logic [6:0] v);
        int g, p;
        value = v;
        count_while(1'b0, g);
        chk({name, "_start"}, g, 1);
        count_while(1'b1, p);
        chk({name, "_busy_len"}, p, 8);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int g0, p1, g1, p2;
        clc   = 1'b0;
        value = 7'd0;
        repeat (2) @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 3'b111);
        chk("rst_busy", busy, 0);

        // First conversion is forced by dirty even though value stays 0.
        clc = 1'b1;
        count_while(1'b0, g0);
        chk("first_start", g0, 1);
        count_while(1'b1, p1);
        chk("first_busy_len", p1, 8);
        repeat (2) @(negedge clk);
        capture("v0", ZERO_LEAD, ZERO_LEAD, 7'h40);

        convert("v127", 7'd127);
        capture("v127", 7'h79, 7'h24, 7'h78);

        // 59 then 60 during SHIFT: two back-to-back conversions.
        value = 7'd59;
        fork
            begin
                repeat (3) @(negedge clk);
                value = 7'd60;
            end
            begin
                count_while(1'b0, g0);
                count_while(1'b1, p1);
                count_while(1'b0, g1);
                count_while(1'b1, p2);
            end
        join
        chk("b2b_start", g0, 1);
        chk("b2b_busy1", p1, 8);
        chk("b2b_gap", g1, 1);
        chk("b2b_busy2", p2, 8);
        repeat (2) @(negedge clk);
        capture("v60", ZERO_LEAD, 7'h02, 7'h40);

        convert("v100", 7'd100);
        capture("v100", 7'h79, 7'h40, 7'h40);

        convert("v7", 7'd7);
        capture("v7", ZERO_LEAD, ZERO_LEAD, 7'h78);

        // Reset in the middle of SHIFT.
        value = 7'd42;
        repeat (3) @(negedge clk);
        #2 clc = 1'b0;
        #1;
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_an", an, 3'b111);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        clc = 1'b1;
        count_while(1'b0, g0);
        chk("rst42_start", g0, 1);
        count_while(1'b1, p1);
        chk("rst42_busy_len", p1, 8);
        repeat (2) @(negedge clk);
        capture("v42", ZERO_LEAD, 7'h19, 7'h24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Downstream stage of the up/down counter: takes the 7-bit binary count, converts it to three BCD digits with a sequential shift-add-3 engine, and time-multiplexes them onto a common-segment, three-digit seven-segment display. It replaces the single-digit combinational decoder whenever the count must be shown in decimal across several digits. All outputs are registered.

## Interface
- REFRESH_DIV, 50000: clk cycles each digit stays lit; legal range 2..2^20.
- clk  in  1  system clock.
- clc  in  1  reset; asynchronous, active-low.
- value  in  7  binary count to display, 0..127.
- seg  out  7  segments {g,f,e,d,c,b,a}; active-low.
- an  out  3  digit enables; active-low, one-hot; an[0]=units, an[1]=tens, an[2]=hundreds.
- busy  out  1  high while a conversion is in progress.

## Operation
- Converter FSM states: IDLE, SHIFT, LOAD.
- IDLE: if `value` differs from `last_value`, or `dirty` is set: capture `value` into the shift register and `last_value`, clear `dirty`, clear the BCD scratch register, go to SHIFT.
- SHIFT: exactly 7 cycles. Each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
- LOAD: copy the scratch BCD into the display digit registers `hund`, `tens`, `units` in one cycle, then return to IDLE.
- `value` changes during SHIFT or LOAD are ignored. IDLE re-evaluates on the next cycle, so the final value is always displayed.
- `busy` is 1 in SHIFT and LOAD, 0 in IDLE.
- Scanner:
  - 20-bit refresh counter counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, the 2-bit index advances 0→1→2→0. Index value 3 is never reached.
  - Registered outputs: `an` = ~(1<<idx); `seg` = encoding of the digit selected by idx.
- Encoding, 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Nibbles >9 cannot occur; if one does, drive 7F.

## Timing
- Reset values:
  - FSM = IDLE; `dirty` = 1; `last_value` = 0; digits = 0.
  - Refresh counter = 0; idx = 0.
  - `seg` = 7F; `an` = 111; `busy` = 0.
- Conversion latency: `value` sampled in IDLE at edge N. SHIFT occupies edges N+1..N+7, LOAD edge N+8. New digits are visible on `seg` from edge N+9, at the latest when the corresponding digit is next scanned.
- First conversion after reset release starts on the first clk edge, because `dirty` = 1.
- `seg`/`an` lag idx/digits by one registered stage. `seg` and `an` change on the same edge, so no mixed digit is ever driven.
- Each digit is lit for exactly REFRESH_DIV cycles. Full frame = 3·REFRESH_DIV cycles.
- Reset asserted mid-conversion: FSM returns to IDLE and digits clear immediately. A fresh conversion follows release.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - when `hund`=0, its slot drives `seg`=7F;
  - when `hund`=0 and `tens`=0, the tens slot also drives 7F;
  - `an` keeps scanning normally; units is never blanked.
- Undefined: all three digits are always shown, so 7 displays as "007".

## Structure
- Package `seg_pkg`:
  - digit-count constant (3);
  - converter state enum {IDLE, SHIFT, LOAD};
  - ten-entry active-low segment constant table;
  - blank code 7F.
- Sub-module `bin2bcd_seq`: the converter FSM, with start/busy/done and a 12-bit BCD output.
- The top level holds the digit registers, scanner and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset, then `value`=0 held: `busy` high for 8 cycles. After that, the scan shows units 40 on an=110, tens 40 on 101, hundreds 40 on 011 (each slot 7F if blanking is enabled, except units 40). Each digit is lit 4 cycles.
- `value`=127: hundreds 79, tens 24, units 78.
- `value`=59 then 60 three cycles later (mid-SHIFT): first 5/9 is loaded, then a second conversion runs. Final digits are 0,6,0; `busy` shows two back-to-back 8-cycle pulses separated by one IDLE cycle.
- `value`=100: digits 1,0,0. With LEADING_ZERO_BLANK_EN, tens still shows 40 because it is not a leading zero.
- `value`=7 with LEADING_ZERO_BLANK_EN: hundreds and tens slots show 7F, units shows 78. Without the macro they show 40, 40, 78.
- `clc` pulsed low mid-SHIFT: `seg`=7F and `an`=111 asynchronously. After release, the conversion restarts and the correct digits appear within 9 cycles plus the scan position.
